// File: rtl/cache_victim_ctrl_pkg.sv
// Shared types and constants for the victim-way selection controller:
// FSM state encoding, LFSR tap masks and the way-index width helper.
package cache_victim_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    FILL   = 2'd2
  } state_e;

  // Number of bits needed to index NUMWAYS ways (NUMWAYS is a power of two).
  function automatic int log2ways(input int n);
    int r;
    r = 32'sd0;
    for (int i = 0; i < 8; i++) begin
      if ((32'sd1 <<< i) < n) r = i + 32'sd1;
      else r = r;
    end
    return r;
  endfunction

  // Maximal-length Fibonacci taps for LFSR widths 3..9; bit k set = lfsr[k] feeds the XOR.
  function automatic logic [8:0] tap_mask(input int lw);
    logic [8:0] m;
    case (lw)
      32'sd3:  m = 9'b000000110;
      32'sd4:  m = 9'b000001100;
      32'sd5:  m = 9'b000010100;
      32'sd6:  m = 9'b000110000;
      32'sd7:  m = 9'b001100000;
      32'sd8:  m = 9'b010111000;
      32'sd9:  m = 9'b100010000;
      default: m = 9'b000001100;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/cache_victim_ctrl_if.sv
// Miss-request / victim handshake bundle between the cache pipeline (master)
// and the victim controller (slave).
interface cache_victim_ctrl_if #(
  parameter int NUMWAYS = 4
) ();
  logic               FlushStage;
  logic               MissReq;
  logic               MissReady;
  logic [NUMWAYS-1:0] ValidWay;
  logic [NUMWAYS-1:0] LockedWay;
  logic [NUMWAYS-1:0] VictimWay;
  logic               VictimValid;
  logic               VictimWasInvalid;
  logic               NoVictim;
  logic               FillDone;

  modport master (
    output FlushStage, MissReq, ValidWay, LockedWay, FillDone,
    input  MissReady, VictimWay, VictimValid, VictimWasInvalid, NoVictim
  );

  modport slave (
    input  FlushStage, MissReq, ValidWay, LockedWay, FillDone,
    output MissReady, VictimWay, VictimValid, VictimWasInvalid, NoVictim
  );
endinterface

// File: rtl/cache_victim_ctrl_rot_priority_pick.sv
// Combinational one-hot search for the first set request bit at or above
// 'start', wrapping from the top way back to way 0.
module rot_priority_pick
  import cache_victim_pkg::*;
#(
  parameter int NUMWAYS = 4
) (
  input  logic [NUMWAYS-1:0]           req,
  input  logic [log2ways(NUMWAYS)-1:0] start,
  output logic [NUMWAYS-1:0]           pick,
  output logic                         hit
);
  localparam int IW = log2ways(NUMWAYS);

  logic [IW-1:0] idx_s;

  // Scan ways in rotated order; index arithmetic wraps because NUMWAYS is a power of two.
  always_comb begin
    pick  = {NUMWAYS{1'b0}};
    hit   = 1'b0;
    idx_s = {IW{1'b0}};
    for (int i = 0; i < NUMWAYS; i++) begin
      idx_s       = start + i[IW-1:0];
      pick[idx_s] = pick[idx_s] | (req[idx_s] & ~hit);
      hit         = hit | req[idx_s];
    end
  end

endmodule

// File: rtl/cache_victim_ctrl.sv
// Victim-way selection controller for a set-associative cache miss.
// Defining VICTIM_PERF_CNT_EN adds saturating per-path fill counters.
module cache_victim_ctrl
  import cache_victim_pkg::*;
#(
  parameter int NUMWAYS = 4,
  parameter int SEED    = 1
) (
  input  logic        clk,
  input  logic        reset,
`ifdef VICTIM_PERF_CNT_EN
  output logic [31:0] InvalidFillCnt,
  output logic [31:0] RandomEvictCnt,
`endif
  cache_victim_ctrl_if.slave bus
);
  localparam int         IW   = log2ways(NUMWAYS);
  localparam int         LW   = IW + 2;
  localparam logic [8:0] TAPS = tap_mask(LW);

  state_e             state_r, next_state_s;
  logic [NUMWAYS-1:0] valid_r, locked_r, victim_way_r, victim_way_s;
  logic [NUMWAYS-1:0] cand_s, free_s, inv_pick_s, rnd_pick_s;
  logic               inv_hit_s, rnd_hit_s;
  logic [LW-1:0]      lfsr_r;
  logic               victim_valid_r, victim_valid_s;
  logic               was_invalid_r, was_invalid_s;
  logic               no_victim_r, no_victim_s;
  logic               miss_ready_r;
  logic               capture_s, advance_s;

  assign cand_s = ~locked_r;
  assign free_s = ~valid_r & cand_s;

  rot_priority_pick #(.NUMWAYS(NUMWAYS)) u_inv_pick (
    .req   (free_s),
    .start ({IW{1'b0}}),
    .pick  (inv_pick_s),
    .hit   (inv_hit_s)
  );

  rot_priority_pick #(.NUMWAYS(NUMWAYS)) u_rnd_pick (
    .req   (cand_s),
    .start (lfsr_r[IW-1:0]),
    .pick  (rnd_pick_s),
    .hit   (rnd_hit_s)
  );

  // Next-state and next-output decode; flush always wins over progress.
  always_comb begin
    next_state_s   = state_r;
    victim_way_s   = victim_way_r;
    victim_valid_s = victim_valid_r;
    was_invalid_s  = was_invalid_r;
    no_victim_s    = 1'b0;
    capture_s      = 1'b0;
    advance_s      = 1'b0;
    case (state_r)
      IDLE: begin
        victim_way_s   = {NUMWAYS{1'b0}};
        victim_valid_s = 1'b0;
        was_invalid_s  = 1'b0;
        if (bus.MissReq && !bus.FlushStage) begin
          next_state_s = SELECT;
          capture_s    = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      SELECT: begin
        if (bus.FlushStage) begin
          next_state_s = IDLE;
        end else if (inv_hit_s) begin
          next_state_s   = FILL;
          victim_way_s   = inv_pick_s;
          victim_valid_s = 1'b1;
          was_invalid_s  = 1'b1;
        end else if (rnd_hit_s) begin
          next_state_s   = FILL;
          victim_way_s   = rnd_pick_s;
          victim_valid_s = 1'b1;
          was_invalid_s  = 1'b0;
        end else begin
          next_state_s = IDLE;
          no_victim_s  = 1'b1;
        end
      end
      FILL: begin
        if (bus.FlushStage || bus.FillDone) begin
          next_state_s   = IDLE;
          victim_way_s   = {NUMWAYS{1'b0}};
          victim_valid_s = 1'b0;
          was_invalid_s  = 1'b0;
          advance_s      = ~bus.FlushStage;
        end else begin
          next_state_s = FILL;
        end
      end
      default: begin
        next_state_s   = IDLE;
        victim_way_s   = {NUMWAYS{1'b0}};
        victim_valid_s = 1'b0;
        was_invalid_s  = 1'b0;
      end
    endcase
  end

  // State, snapshot, LFSR and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= IDLE;
      lfsr_r         <= SEED[LW-1:0];
      valid_r        <= {NUMWAYS{1'b0}};
      locked_r       <= {NUMWAYS{1'b0}};
      victim_way_r   <= {NUMWAYS{1'b0}};
      victim_valid_r <= 1'b0;
      was_invalid_r  <= 1'b0;
      no_victim_r    <= 1'b0;
      miss_ready_r   <= 1'b1;
    end else begin
      state_r        <= next_state_s;
      victim_way_r   <= victim_way_s;
      victim_valid_r <= victim_valid_s;
      was_invalid_r  <= was_invalid_s;
      no_victim_r    <= no_victim_s;
      miss_ready_r   <= (next_state_s == IDLE);
      if (capture_s) begin
        valid_r  <= bus.ValidWay;
        locked_r <= bus.LockedWay;
      end
      if (advance_s) begin
        lfsr_r <= {lfsr_r[LW-2:0], ^(lfsr_r & TAPS[LW-1:0])};
      end
    end
  end

  assign bus.MissReady        = miss_ready_r;
  assign bus.VictimWay        = victim_way_r;
  assign bus.VictimValid      = victim_valid_r;
  assign bus.VictimWasInvalid = was_invalid_r;
  assign bus.NoVictim         = no_victim_r;

`ifdef VICTIM_PERF_CNT_EN
  logic [31:0] inv_cnt_r, rnd_cnt_r;

  // Committed-fill counters split by victim path, saturating at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inv_cnt_r <= 32'd0;
      rnd_cnt_r <= 32'd0;
    end else if (advance_s) begin
      if (was_invalid_r && (inv_cnt_r != 32'hFFFF_FFFF)) inv_cnt_r <= inv_cnt_r + 32'd1;
      if (!was_invalid_r && (rnd_cnt_r != 32'hFFFF_FFFF)) rnd_cnt_r <= rnd_cnt_r + 32'd1;
    end
  end

  assign InvalidFillCnt = inv_cnt_r;
  assign RandomEvictCnt = rnd_cnt_r;
`endif

endmodule

// File: tb/tb_cache_victim_ctrl.sv
// Directed plus randomized bench for cache_victim_ctrl (NUMWAYS=4, SEED=1),
// checked against a behavioural victim-choice and LFSR model.
module tb_cache_victim_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [3:0] m_lfsr;
  int         m_inv_fills;
  int         m_rnd_fills;
  bit         m_last_inv;

  cache_victim_ctrl_if #(.NUMWAYS(4)) bus ();

`ifdef VICTIM_PERF_CNT_EN
  logic [31:0] inv_cnt;
  logic [31:0] rnd_cnt;
`endif

  cache_victim_ctrl #(.NUMWAYS(4), .SEED(1)) dut (
    .clk            (clk),
    .reset          (reset),
`ifdef VICTIM_PERF_CNT_EN
    .InvalidFillCnt (inv_cnt),
    .RandomEvictCnt (rnd_cnt),
`endif
    .bus            (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Victim per the selection rules: lowest free unlocked way, else first unlocked way from lfsr%4 upward.
  function automatic void ref_pick(input logic [3:0] v, input logic [3:0] l, input logic [3:0] lf,
                                   output logic [3:0] w, output bit inv, output bit none);
    int start;
    w    = 4'b0000;
    inv  = 1'b0;
    none = (l == 4'b1111);
    for (int k = 0; k < 4; k++) begin
      if (!v[k] && !l[k] && w == 4'b0000) begin
        w   = 4'b0001 << k;
        inv = 1'b1;
      end
    end
    if (w == 4'b0000 && !none) begin
      start = int'(lf) % 4;
      for (int k = 0; k < 4; k++) begin
        int j;
        j = (start + k) % 4;
        if (!l[j] && w == 4'b0000) w = 4'b0001 << j;
      end
    end
  endfunction

  function automatic logic [3:0] lfsr_next(input logic [3:0] x);
    return {x[2:0], x[3] ^ x[2]};
  endfunction

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    reset        = 1'b0;
    m_lfsr       = 4'b0001;
    m_inv_fills  = 0;
    m_rnd_fills  = 0;
  endtask

  // Issue one miss from IDLE; returns whether the DUT is now in FILL with victim ew.
  task automatic miss(input logic [3:0] v, input logic [3:0] l, input bit flush_sel,
                      output bit in_fill, output logic [3:0] ew);
    bit einv, enone;
    ref_pick(v, l, m_lfsr, ew, einv, enone);
    bus.MissReq   = 1'b1;
    bus.ValidWay  = v;
    bus.LockedWay = l;
    tick();
    bus.MissReq   = 1'b0;
    bus.ValidWay  = 4'($urandom_range(0, 15));
    bus.LockedWay = 4'($urandom_range(0, 15));
    chk("accept_ready_low", bus.MissReady, 1'b0);
    chk("accept_valid_low", bus.VictimValid, 1'b0);
    bus.FlushStage = flush_sel;
    tick();
    bus.FlushStage = 1'b0;
    in_fill = 1'b0;
    if (flush_sel) begin
      chk("selflush_valid", bus.VictimValid, 1'b0);
      chk("selflush_novictim", bus.NoVictim, 1'b0);
      chk("selflush_ready", bus.MissReady, 1'b1);
    end else if (enone) begin
      chk("novictim_pulse", bus.NoVictim, 1'b1);
      chk("novictim_valid", bus.VictimValid, 1'b0);
      chk("novictim_ready", bus.MissReady, 1'b1);
      tick();
      chk("novictim_end", bus.NoVictim, 1'b0);
      chk("novictim_valid2", bus.VictimValid, 1'b0);
    end else begin
      tick();
      chk("fill_valid", bus.VictimValid, 1'b1);
      chk("fill_way", bus.VictimWay, ew);
      chk("fill_wasinv", bus.VictimWasInvalid, einv);
      chk("fill_ready_low", bus.MissReady, 1'b0);
      m_last_inv = einv;
      in_fill    = 1'b1;
    end
  endtask

  // End a FILL: mode 0 = FillDone, 1 = FlushStage, 2 = both together.
  task automatic finish_fill(input int mode);
    bus.FillDone   = (mode != 1);
    bus.FlushStage = (mode != 0);
    tick();
    bus.FillDone   = 1'b0;
    bus.FlushStage = 1'b0;
    chk("end_valid", bus.VictimValid, 1'b0);
    chk("end_way", bus.VictimWay, 4'b0000);
    chk("end_ready", bus.MissReady, 1'b1);
    if (mode == 0) begin
      m_lfsr = lfsr_next(m_lfsr);
      if (m_last_inv) m_inv_fills++;
      else m_rnd_fills++;
    end
  endtask

  initial begin
    bit         inf;
    logic [3:0] ew, ew_prev;
    bit         einv, enone;

    bus.MissReq    = 1'b0;
    bus.FlushStage = 1'b0;
    bus.FillDone   = 1'b0;
    bus.ValidWay   = 4'b0000;
    bus.LockedWay  = 4'b0000;
    reset          = 1'b1;
    m_lfsr         = 4'b0001;
    m_inv_fills    = 0;
    m_rnd_fills    = 0;
    m_last_inv     = 1'b0;
    tick();
    chk("rst_ready", bus.MissReady, 1'b1);
    chk("rst_valid", bus.VictimValid, 1'b0);
    chk("rst_way", bus.VictimWay, 4'b0000);
    chk("rst_wasinv", bus.VictimWasInvalid, 1'b0);
    chk("rst_novictim", bus.NoVictim, 1'b0);
    tick();
    reset = 1'b0;

    // FillDone in IDLE must not advance the LFSR.
    bus.FillDone = 1'b1;
    tick();
    bus.FillDone = 1'b0;
    chk("idle_filldone_ready", bus.MissReady, 1'b1);
    chk("idle_filldone_valid", bus.VictimValid, 1'b0);

    // Invalid path: way 2 is the only free way.
    miss(4'b1011, 4'b0000, 1'b0, inf, ew);
    finish_fill(0);

    // Random path from a fresh reset, then a second random miss.
    apply_reset();
    miss(4'b1111, 4'b0000, 1'b0, inf, ew);
    finish_fill(0);
    miss(4'b1111, 4'b0000, 1'b0, inf, ew);
    finish_fill(0);

    // Advance until the random start index is 3, then lock way 3 to force a wrap.
    for (int n = 0; n < 16 && m_lfsr[1:0] != 2'b11; n++) begin
      miss(4'b1111, 4'b0000, 1'b0, inf, ew);
      finish_fill(0);
    end
    chk("wrap_setup_idx", {30'd0, m_lfsr[1:0]}, 32'd3);
    miss(4'b1111, 4'b1000, 1'b0, inf, ew);
    finish_fill(0);

    // All locked: NoVictim pulse, LFSR untouched.
    miss(4'b0101, 4'b1111, 1'b0, inf, ew);
    miss(4'b1111, 4'b0000, 1'b0, inf, ew);
    ew_prev = ew;
    finish_fill(2);
    miss(4'b1111, 4'b0000, 1'b0, inf, ew);
    chk("flush_same_victim", ew, ew_prev);
    finish_fill(1);

    // Flush during SELECT.
    miss(4'b0000, 4'b0000, 1'b1, inf, ew);

    // MissReq held during FILL is not accepted until IDLE.
    miss(4'b1111, 4'b0000, 1'b0, inf, ew);
    bus.MissReq   = 1'b1;
    bus.ValidWay  = 4'b1111;
    bus.LockedWay = 4'b0000;
    repeat (2) begin
      tick();
      chk("held_req_ready", bus.MissReady, 1'b0);
      chk("held_req_way", bus.VictimWay, ew);
    end
    bus.FillDone = 1'b1;
    tick();
    bus.FillDone = 1'b0;
    m_lfsr = lfsr_next(m_lfsr);
    m_rnd_fills++;
    chk("held_req_idle", bus.MissReady, 1'b1);
    chk("held_req_cleared", bus.VictimValid, 1'b0);
    ref_pick(4'b1111, 4'b0000, m_lfsr, ew, einv, enone);
    tick();
    bus.MissReq = 1'b0;
    chk("held_req_accepted", bus.MissReady, 1'b0);
    tick();
    tick();
    chk("held_fill_valid", bus.VictimValid, 1'b1);
    chk("held_fill_way", bus.VictimWay, ew);

    // Asynchronous reset mid-FILL, away from any clock edge.
    #3 reset = 1'b1;
    #1;
    chk("async_rst_valid", bus.VictimValid, 1'b0);
    chk("async_rst_way", bus.VictimWay, 4'b0000);
    chk("async_rst_ready", bus.MissReady, 1'b1);
    tick();
    reset       = 1'b0;
    m_lfsr      = 4'b0001;
    m_inv_fills = 0;
    m_rnd_fills = 0;
    miss(4'b1111, 4'b0000, 1'b0, inf, ew);
    chk("post_rst_seed_victim", ew, bus.VictimWay);
    finish_fill(0);

    // Randomized misses with random endings.
    for (int n = 0; n < 60; n++) begin
      logic [3:0] v, l;
      int r;
      v = 4'($urandom_range(0, 15));
      l = ($urandom_range(0, 5) == 0) ? 4'b1111 : 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      miss(v, l, ($urandom_range(0, 9) == 0), inf, ew);
      if (inf) begin
        repeat ($urandom_range(0, 2)) begin
          tick();
          chk("rand_hold_way", bus.VictimWay, ew);
          chk("rand_hold_valid", bus.VictimValid, 1'b1);
        end
        r = $urandom_range(0, 5);
        finish_fill((r == 0) ? 1 : ((r == 1) ? 2 : 0));
      end
    end

`ifdef VICTIM_PERF_CNT_EN
    chk("perf_invalid_cnt", inv_cnt, 32'(m_inv_fills));
    chk("perf_random_cnt", rnd_cnt, 32'(m_rnd_fills));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
